// File: rtl/aes_uart_block_loader_if.sv
// Byte-in / block-out bundle between the UART receiver, the loader and the AES core.
// master is the loader's view; slave is the view of whoever feeds bytes and watches the outputs.
interface aes_uart_block_loader_if;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         enable;
  logic         busy;
  logic         cypher_valid;
  logic         frame_err;

  modport master (
    input  rx_data, rx_valid,
    output key, plaintext, enable, busy, cypher_valid, frame_err
  );

  modport slave (
    output rx_data, rx_valid,
    input  key, plaintext, enable, busy, cypher_valid, frame_err
  );
endinterface

// File: rtl/aes_uart_block_loader.sv
// Assembles 16 key + 16 plaintext UART bytes into the AES core inputs and times the core's cypher output.
// Optional: define AES_LOADER_KEY_REUSE_EN to keep the first committed key and accept plaintext-only frames.
module aes_uart_block_loader #(
  parameter int BYTES_PER_BLOCK = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int PIPE_LATENCY    = 24
) (
  input logic clk,
  input logic reset,
  aes_uart_block_loader_if.master bus
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int LAT_W  = $clog2(PIPE_LATENCY + 1);
  localparam logic [3:0]        COUNT_LAST = 4'(BYTES_PER_BLOCK - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(PIPE_LATENCY - 1);
  localparam logic [LAT_W-1:0]  LAT_DONE   = LAT_W'(PIPE_LATENCY);

  typedef enum logic [1:0] {RX_KEY, RX_PT, HOLD} state_t;

  state_t            state, state_next;
  logic [3:0]        count, count_next;
  logic [IDLE_W-1:0] idle, idle_next;
  logic [LAT_W-1:0]  lat, lat_next;
  logic [127:0]      key_stage;
  // The 16th plaintext byte goes straight to the output, so only 15 bytes are staged.
  logic [119:0]      pt_stage;
  logic              busy, timeout, shift_key, shift_pt, commit, cv_next, ferr_next;

`ifdef AES_LOADER_KEY_REUSE_EN
  logic key_loaded;

  // Once a key is held, RX_PT with nothing received is just waiting for the next frame.
  assign busy = (state == RX_KEY && count != 4'd0) ||
                (state == RX_PT && (count != 4'd0 || !key_loaded));
`else
  assign busy = (state == RX_KEY && count != 4'd0) || (state == RX_PT);
`endif

  assign timeout  = busy && !bus.rx_valid && (idle == IDLE_LAST);
  assign bus.busy = busy;

  always_comb begin
    state_next = state;
    count_next = count;
    lat_next   = lat;
    shift_key  = 1'b0;
    shift_pt   = 1'b0;
    commit     = 1'b0;
    cv_next    = 1'b0;
    ferr_next  = 1'b0;
    idle_next  = (bus.rx_valid || !busy || timeout) ? '0 : idle + 1'b1;

    case (state)
      RX_KEY: begin
        if (bus.rx_valid) begin
          shift_key = 1'b1;
          if (count == COUNT_LAST) begin
            state_next = RX_PT;
            count_next = 4'd0;
          end else begin
            count_next = count + 4'd1;
          end
        end
      end
      RX_PT: begin
        if (bus.rx_valid) begin
          shift_pt = 1'b1;
          if (count == COUNT_LAST) begin
            commit     = 1'b1;
            state_next = HOLD;
            count_next = 4'd0;
            lat_next   = '0;
          end else begin
            count_next = count + 4'd1;
          end
        end
      end
      HOLD: begin
        // A new byte abandons the pending cypher strobe and starts the next frame.
        if (bus.rx_valid) begin
          count_next = 4'd1;
`ifdef AES_LOADER_KEY_REUSE_EN
          shift_pt   = 1'b1;
          state_next = RX_PT;
`else
          shift_key  = 1'b1;
          state_next = RX_KEY;
`endif
        end else if (lat != LAT_DONE) begin
          lat_next = lat + 1'b1;
          cv_next  = (lat == LAT_LAST);
        end
      end
      default: state_next = RX_KEY;
    endcase

    if (timeout) begin
      count_next = 4'd0;
      ferr_next  = 1'b1;
`ifdef AES_LOADER_KEY_REUSE_EN
      state_next = key_loaded ? RX_PT : RX_KEY;
`else
      state_next = RX_KEY;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RX_KEY;
      count            <= 4'd0;
      idle             <= '0;
      lat              <= '0;
      key_stage        <= '0;
      pt_stage         <= '0;
      bus.key          <= '0;
      bus.plaintext    <= '0;
      bus.enable       <= 1'b0;
      bus.cypher_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
      key_loaded       <= 1'b0;
`endif
    end else begin
      state            <= state_next;
      count            <= count_next;
      idle             <= idle_next;
      lat              <= lat_next;
      bus.enable       <= (state_next == HOLD);
      bus.cypher_valid <= cv_next;
      bus.frame_err    <= ferr_next;
      if (timeout) begin
        pt_stage <= '0;
`ifdef AES_LOADER_KEY_REUSE_EN
        if (!key_loaded) key_stage <= '0;
`else
        key_stage <= '0;
`endif
      end else begin
        if (shift_key) key_stage <= {key_stage[119:0], bus.rx_data};
        if (shift_pt)  pt_stage  <= {pt_stage[111:0], bus.rx_data};
      end
      if (commit) begin
        bus.key       <= key_stage;
        bus.plaintext <= {pt_stage, bus.rx_data};
`ifdef AES_LOADER_KEY_REUSE_EN
        key_loaded    <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_aes_uart_block_loader.sv
// Scoreboard bench for aes_uart_block_loader: stimulus queues expected commit/cypher/frame-error events, a monitor checks them.
// Honours AES_LOADER_KEY_REUSE_EN to run the plaintext-only frame scenario.
module tb_aes_uart_block_loader;
  localparam int TO = 50;
  localparam int PL = 24;
  localparam int K_COMMIT = 0;
  localparam int K_CV     = 1;
  localparam int K_FERR   = 2;

  localparam logic [255:0] F1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff};
  localparam logic [255:0] F2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734};
  localparam logic [255:0] F3A = {128'h0f0e0d0c0b0a09080706050403020100, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};
  localparam logic [255:0] F3B = {128'haabbccddeeff00112233445566778899, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] FJ  = {128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'hcafef00dcafef00dcafef00dcafef00d};
  localparam logic [255:0] F5  = {128'h8e73b0f7da0e6452c810f32b809079e5, 128'h6bc1bee22e409f96e93d7e117393172a};
  localparam logic [255:0] F6  = {128'h603deb1015ca71be2b73aef0857d7781, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
  localparam logic [255:0] FR  = {128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddccbbaa99887766554433221100};

  typedef struct {
    int           kind;
    int           cyc;
    logic [127:0] key;
    logic [127:0] pt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic en_prev = 1'b0;
  exp_t sb[$];

  aes_uart_block_loader_if lif ();

  aes_uart_block_loader #(
    .BYTES_PER_BLOCK(16),
    .TIMEOUT_CYCLES (TO),
    .PIPE_LATENCY   (PL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (lif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int at, input logic [255:0] f);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    e.key  = f[255:128];
    e.pt   = f[127:0];
    sb.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected event: got kind %0d at cycle %0d, wanted none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check_output("event kind", kind, e.kind);
      check_output("event cycle", cyc, e.cyc);
      if (kind == K_COMMIT && e.kind == K_COMMIT) begin
        check_output("commit key", lif.key, e.key);
        check_output("commit plaintext", lif.plaintext, e.pt);
      end
    end
  endtask

  // Monitor: every visible output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (lif.enable && !en_prev) observe(K_COMMIT);
      if (lif.cypher_valid) observe(K_CV);
      if (lif.frame_err) observe(K_FERR);
    end
    en_prev = lif.enable;
  end

  task automatic send_byte(input logic [7:0] b);
    lif.rx_data  = b;
    lif.rx_valid = 1'b1;
    @(negedge clk);
    lif.rx_valid = 1'b0;
  endtask

  // Sends bytes lo..hi of a 32-byte frame; expectations go in before the final byte's strobe.
  task automatic apply_stimulus(input logic [255:0] f, input int lo, input int hi,
                                input bit commit, input bit cv);
    for (int i = lo; i <= hi; i++) begin
      if (i == hi && commit) begin
        push_exp(K_COMMIT, cyc + 1, f);
        if (cv) push_exp(K_CV, cyc + 1 + PL, f);
      end
      send_byte(f[255-8*i -: 8]);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lif.rx_data  = 8'h00;
    lif.rx_valid = 1'b0;
    idle_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check_output("reset key", lif.key, 128'h0);
    check_output("reset plaintext", lif.plaintext, 128'h0);
    check_output("reset enable", lif.enable, 1'b0);
    check_output("reset busy", lif.busy, 1'b0);
    check_output("reset cypher_valid", lif.cypher_valid, 1'b0);
    check_output("reset frame_err", lif.frame_err, 1'b0);

    $display("[TB] basic 32-byte frame");
    apply_stimulus(F1, 0, 9, 0, 0);
    check_output("busy mid key", lif.busy, 1'b1);
    apply_stimulus(F1, 10, 31, 1, 1);
    check_output("enable in hold", lif.enable, 1'b1);
    check_output("busy in hold", lif.busy, 1'b0);
    idle_cycles(30);

`ifdef AES_LOADER_KEY_REUSE_EN
    $display("[TB] plaintext-only frame with retained key");
    apply_stimulus(FR, 16, 16, 0, 0);
    check_output("enable drops on reuse frame", lif.enable, 1'b0);
    check_output("busy on reuse frame", lif.busy, 1'b1);
    apply_stimulus(FR, 17, 31, 1, 1);
    check_output("key retained", lif.key, F1[255:128]);
    idle_cycles(30);
`else
    // frame_err appears on the cycle after the TO-th idle clock following the last byte.
    $display("[TB] partial frame timeout");
    apply_stimulus(FJ, 0, 8, 0, 0);
    push_exp(K_FERR, cyc + TO + 1, FJ);
    send_byte(FJ[255-8*9 -: 8]);
    check_output("busy partial", lif.busy, 1'b1);
    check_output("enable partial", lif.enable, 1'b0);
    idle_cycles(TO + 5);
    check_output("busy after timeout", lif.busy, 1'b0);
    check_output("enable after timeout", lif.enable, 1'b0);
    check_output("key after timeout", lif.key, F1[255:128]);
    check_output("plaintext after timeout", lif.plaintext, F1[127:0]);
    apply_stimulus(F2, 0, 31, 1, 1);
    idle_cycles(30);

    $display("[TB] new frame interrupts hold");
    apply_stimulus(F3A, 0, 31, 1, 0);
    idle_cycles(5);
    apply_stimulus(F3B, 0, 0, 0, 0);
    check_output("enable drops after hold byte", lif.enable, 1'b0);
    apply_stimulus(F3B, 1, 31, 1, 1);
    check_output("new key top byte", lif.key[127:120], 8'haa);
    idle_cycles(30);

    $display("[TB] reset mid frame");
    apply_stimulus(FJ, 0, 19, 0, 0);
    reset = 1'b1;
    #1;
    check_output("mid reset key", lif.key, 128'h0);
    check_output("mid reset plaintext", lif.plaintext, 128'h0);
    check_output("mid reset enable", lif.enable, 1'b0);
    check_output("mid reset busy", lif.busy, 1'b0);
    check_output("mid reset cypher_valid", lif.cypher_valid, 1'b0);
    check_output("mid reset frame_err", lif.frame_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(F5, 0, 31, 1, 1);
    idle_cycles(30);

    $display("[TB] byte on the timeout boundary");
    apply_stimulus(F6, 0, 9, 0, 0);
    idle_cycles(TO - 1);
    apply_stimulus(F6, 10, 10, 0, 0);
    check_output("busy after boundary byte", lif.busy, 1'b1);
    apply_stimulus(F6, 11, 31, 1, 1);
    idle_cycles(30);
`endif

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check_output("scoreboard drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
